// File: rtl/nios2_dbg_pkg.sv
// Shared types, default widths and the IR one-hot decoder for the JTAG debug command path.
package nios2_dbg_pkg;

  localparam int unsigned DBG_IR_W     = 2;
  localparam int unsigned DBG_DATA_W   = 38;
  localparam int unsigned DBG_ACT_BIT  = DBG_DATA_W - 4;
  // Widest IR the decoder supports; callers cast the result down to 2**IR_W bits.
  localparam int unsigned DBG_IR_W_MAX = 8;

  typedef struct packed {
    logic [DBG_IR_W-1:0]   ir;
    logic [DBG_DATA_W-1:0] data;
  } dbg_cmd_t;

  function automatic logic [2**DBG_IR_W_MAX-1:0] onehot_decode(input logic [DBG_IR_W_MAX-1:0] ir);
    logic [2**DBG_IR_W_MAX-1:0] oh;
    oh     = '0;
    oh[ir] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Multi-flop synchroniser for the TCK-domain update-DR level plus registered rising-edge pulse.
module nios2_dbg_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/nios2_dbg_cmd_dispatch.sv
// Debug command dispatcher: sync update-DR, queue {ir, sr} in a FWFT FIFO, decode on accept.
// Optional odd-parity check on sr[DATA_W-1] when DEBUG_CMD_PARITY_EN is defined.
module nios2_dbg_cmd_dispatch
  import nios2_dbg_pkg::*;
#(
  parameter int unsigned IR_W        = DBG_IR_W,
  parameter int unsigned DATA_W      = DBG_DATA_W,
  parameter int unsigned ACT_BIT     = DATA_W - 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned NCMD       = 2**IR_W,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              cmd_ready,
  input  logic              clear_overflow,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DATA_W-1:0] jdo,
  output logic [NCMD-1:0]   take_action,
  output logic [NCMD-1:0]   take_no_action,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow
`ifdef DEBUG_CMD_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = IR_W + DATA_W;

  logic              push, in_good, accept, full, buf_empty;
  logic              push_ok, drop, load_out, pop_buf, bypass, wr_buf;
  logic [CW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              out_valid_q;
  logic [IR_W-1:0]   out_ir_q;
  logic [DATA_W-1:0] out_data_q;
  logic [LW-1:0]     level_q;
  logic              overflow_q;
  logic [NCMD-1:0]   dec;

  nios2_dbg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vs_udr),
    .pulse (push)
  );

`ifdef DEBUG_CMD_PARITY_EN
  logic parity_err_q;
  assign in_good = ^sr;

  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= (push & ~in_good) | (parity_err_q & ~clear_overflow);
  end

  assign parity_err = parity_err_q;
`else
  assign in_good = 1'b1;
`endif

  always_comb begin
    accept    = out_valid_q & cmd_ready;
    full      = (level_q == LW'(FIFO_DEPTH));
    push_ok   = push & in_good & (~full | accept);
    drop      = push & in_good & full & ~accept;
    buf_empty = (wr_ptr_q == rd_ptr_q);
    load_out  = accept | ~out_valid_q;
    pop_buf   = load_out & ~buf_empty;
    // Empty buffer behind an empty/draining output register: skip the RAM.
    bypass    = load_out & buf_empty & push_ok;
    wr_buf    = push_ok & ~bypass;
  end

  always_ff @(posedge clk) begin
    if (wr_buf) mem_q[wr_ptr_q[AW-1:0]] <= {ir_in, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_data_q  <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_buf) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_buf) begin
        {out_ir_q, out_data_q} <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q               <= rd_ptr_q + 1'b1;
        out_valid_q            <= 1'b1;
      end else if (bypass) begin
        out_ir_q    <= ir_in;
        out_data_q  <= sr;
        out_valid_q <= 1'b1;
      end else if (load_out) begin
        out_valid_q <= 1'b0;
      end
      level_q    <= level_q + LW'(push_ok) - LW'(accept);
      overflow_q <= drop | (overflow_q & ~clear_overflow);
    end
  end

  assign dec            = NCMD'(onehot_decode(DBG_IR_W_MAX'(out_ir_q)));
  assign take_action    = (accept & out_data_q[ACT_BIT])  ? dec : '0;
  assign take_no_action = (accept & ~out_data_q[ACT_BIT]) ? dec : '0;

  assign cmd_valid  = out_valid_q;
  assign cmd_ir     = out_ir_q;
  assign jdo        = out_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nios2_dbg_cmd_dispatch.sv
// Self-checking bench for nios2_dbg_cmd_dispatch: vector table plus scoreboarded corner sequences.
module tb_nios2_dbg_cmd_dispatch;
  import nios2_dbg_pkg::*;

  localparam int unsigned IR_W        = 2;
  localparam int unsigned DATA_W      = 38;
  localparam int unsigned ACT_BIT     = 34;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset, vs_udr, cmd_ready, clear_overflow;
  logic [IR_W-1:0]   ir_in, cmd_ir;
  logic [DATA_W-1:0] sr, jdo;
  logic              cmd_valid, overflow;
  logic [3:0]        take_action, take_no_action;
  logic [2:0]        fifo_level;
`ifdef DEBUG_CMD_PARITY_EN
  logic              parity_err;
`endif

  int       n_checks = 0;
  int       n_pass   = 0;
  bit       mon_en   = 1'b0;
  dbg_cmd_t exp_q[$];

  typedef struct {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] sr;
    logic [3:0]        exp_ta;
    logic [3:0]        exp_tna;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  nios2_dbg_cmd_dispatch #(
    .IR_W        (IR_W),
    .DATA_W      (DATA_W),
    .ACT_BIT     (ACT_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clear_overflow (clear_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
`ifdef DEBUG_CMD_PARITY_EN
    ,
    .parity_err     (parity_err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Good odd parity in bit 37, action flag in bit 34.
  function automatic logic [DATA_W-1:0] mk_sr(input logic act, input logic [33:0] data);
    logic [DATA_W-1:0] s;
    s     = {1'b0, 2'b00, act, data};
    s[37] = ~^s[36:0];
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raises vs_udr; the push lands on the (SYNC_STAGES+2)th edge, where ready/clear may be forced.
  task automatic push_cmd(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] s,
                          input bit expect_in, input bit ready_at_push, input bit clr_at_push);
    dbg_cmd_t e;
    ir_in = ir;
    sr    = s;
    if (expect_in) begin
      e.ir   = ir;
      e.data = s;
      exp_q.push_back(e);
    end
    vs_udr = 1'b1;
    repeat (SYNC_STAGES + 1) tick;
    if (ready_at_push) cmd_ready = 1'b1;
    clear_overflow = clr_at_push;
    tick;
    clear_overflow = 1'b0;
    if (ready_at_push) cmd_ready = 1'b0;
    vs_udr = 1'b0;
    repeat (SYNC_STAGES + 1) tick;
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int k = 0; k < 20 && fifo_level != 0; k++) tick;
    cmd_ready = 1'b0;
    check({name, "_level0"}, 64'(fifo_level), 64'd0);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every accept must match the oldest expected command.
  always @(negedge clk) begin
    dbg_cmd_t   e;
    logic [3:0] oh;
    if (mon_en && !reset) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_accept", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.ir;
          check("sb_ir", 64'(cmd_ir), 64'(e.ir));
          check("sb_jdo", 64'(jdo), 64'(e.data));
          check("sb_take_action", 64'(take_action), e.data[ACT_BIT] ? 64'(oh) : 64'd0);
          check("sb_take_no_action", 64'(take_no_action), e.data[ACT_BIT] ? 64'd0 : 64'(oh));
        end
      end else begin
        check("idle_no_take", 64'({take_action, take_no_action}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ir: 2'b01, sr: mk_sr(1'b1, 34'h1_2345), exp_ta: 4'b0010, exp_tna: 4'b0000};
    vecs[1] = '{ir: 2'b11, sr: mk_sr(1'b0, 34'h2A),     exp_ta: 4'b0000, exp_tna: 4'b1000};
    vecs[2] = '{ir: 2'b00, sr: mk_sr(1'b1, 34'h0_00FF), exp_ta: 4'b0001, exp_tna: 4'b0000};
    vecs[3] = '{ir: 2'b10, sr: mk_sr(1'b0, 34'h3_C0DE), exp_ta: 4'b0000, exp_tna: 4'b0100};

    reset = 1'b1; vs_udr = 1'b0; cmd_ready = 1'b0; clear_overflow = 1'b0;
    ir_in = '0; sr = '0;
    repeat (3) tick;
    reset = 1'b0;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_data", 64'({cmd_ir, jdo}), 64'd0);
    check("rst_take", 64'({take_action, take_no_action}), 64'd0);
    check("vec1_jdo_const", 64'(vecs[1].sr), 64'h2A);
    mon_en = 1'b1;

    // Single commands: exact latency, data, and a one-cycle decode pulse.
    for (int i = 0; i < 4; i++) begin
      dbg_cmd_t e;
      cmd_ready = 1'b0;
      ir_in     = vecs[i].ir;
      sr        = vecs[i].sr;
      e.ir      = vecs[i].ir;
      e.data    = vecs[i].sr;
      exp_q.push_back(e);
      vs_udr = 1'b1;
      repeat (SYNC_STAGES + 1) tick;
      check("t_lat_early", 64'(cmd_valid), 64'd0);
      tick;
      check("t_lat_valid", 64'(cmd_valid), 64'd1);
      check("t_ir", 64'(cmd_ir), 64'(vecs[i].ir));
      check("t_jdo", 64'(jdo), 64'(vecs[i].sr));
      check("t_level", 64'(fifo_level), 64'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      check("t_take_action", 64'(take_action), 64'(vecs[i].exp_ta));
      check("t_take_no_action", 64'(take_no_action), 64'(vecs[i].exp_tna));
      tick;
      check("t_pulse_once", 64'({cmd_valid, take_action, take_no_action}), 64'd0);
      check("t_level_after", 64'(fifo_level), 64'd0);
      cmd_ready = 1'b0;
      vs_udr    = 1'b0;
      repeat (SYNC_STAGES + 1) tick;
    end

    // Backpressure: five updates into four entries; the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      push_cmd(2'(i), mk_sr(1'(i), 34'(100 + i)), i < 4, 1'b0, 1'b0);
      if (i == 3) begin
        check("ovf_level_full", 64'(fifo_level), 64'd4);
        check("ovf_not_yet", 64'(overflow), 64'd0);
        check("ovf_hold_jdo", 64'(jdo), 64'(mk_sr(1'b0, 34'd100)));
      end
    end
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_set", 64'(overflow), 64'd1);
    drain("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    tick;
    clear_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full + accept in the push cycle: push taken, newest comes out last.
    for (int i = 0; i < 4; i++) push_cmd(2'(3 - i), mk_sr(1'(~i), 34'(200 + i)), 1'b1, 1'b0, 1'b0);
    check("fa_level_before", 64'(fifo_level), 64'd4);
    push_cmd(2'b10, mk_sr(1'b1, 34'h3_1234), 1'b1, 1'b1, 1'b0);
    check("fa_level", 64'(fifo_level), 64'd4);
    check("fa_no_overflow", 64'(overflow), 64'd0);
    drain("fa_drain");

    // Drop with clear in the same cycle: set wins. Then reset mid-queue.
    for (int i = 0; i < 3; i++) push_cmd(2'(i), mk_sr(1'b1, 34'(300 + i)), 1'b1, 1'b0, 1'b0);
    check("rq_level3", 64'(fifo_level), 64'd3);
    push_cmd(2'b11, mk_sr(1'b0, 34'd303), 1'b1, 1'b0, 1'b0);
    push_cmd(2'b01, mk_sr(1'b0, 34'd304), 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 64'(overflow), 64'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_q.delete();
    check("rq_valid", 64'(cmd_valid), 64'd0);
    check("rq_level", 64'(fifo_level), 64'd0);
    check("rq_overflow", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rq_no_take", 64'({cmd_valid, take_action, take_no_action}), 64'd0);
      tick;
    end
    cmd_ready = 1'b0;

`ifdef DEBUG_CMD_PARITY_EN
    push_cmd(2'b01, mk_sr(1'b1, 34'h55) ^ (38'd1 << 37), 1'b0, 1'b0, 1'b0);
    check("par_err_set", 64'(parity_err), 64'd1);
    check("par_level", 64'(fifo_level), 64'd0);
    check("par_no_valid", 64'(cmd_valid), 64'd0);
    push_cmd(2'b10, mk_sr(1'b0, 34'h77) ^ (38'd1 << 37), 1'b0, 1'b0, 1'b1);
    check("par_set_wins", 64'(parity_err), 64'd1);
    check("par_no_overflow", 64'(overflow), 64'd0);
    clear_overflow = 1'b1;
    tick;
    clear_overflow = 1'b0;
    check("par_cleared", 64'(parity_err), 64'd0);
    push_cmd(2'b00, mk_sr(1'b0, 34'h99), 1'b1, 1'b0, 1'b0);
    check("par_good_level", 64'(fifo_level), 64'd1);
    drain("par_drain");
`endif

    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
